// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle doubleword data memory for the MEM stage. A load or store
//   request is latched in IDLE, spends LATENCY cycles in WAIT, and completes
//   at the WAIT->DONE edge. stall holds the pipeline until the DONE cycle.
//   Misaligned or out-of-range accesses raise fault for the DONE cycle only.
// Ports:
//   systemClock  : clock, rising edge
//   reset        : asynchronous, active-high
//   memRead      : load request (held by pipeline while stall=1)
//   memWrite     : store request (held by pipeline while stall=1)
//   address      : byte address
//   writeData    : store data
//   readData     : registered load result, changes only on read completion/reset
//   stall        : request pending, pipeline frozen
//   fault        : faulted access, valid in the DONE cycle
module data_mem_responder #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        systemClock,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [63:0] address,
  input  logic [63:0] writeData,
  output logic [63:0] readData,
  output logic        stall,
  output logic        fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        is_write_q, is_write_d;
  logic [63:0] read_data_q, read_data_d;
  logic        fault_q, fault_d;

  logic                 req;
  logic                 access_fault;
  logic                 mem_we;
  logic                 stall_int;
  logic [ADDR_BITS-1:0] word_idx;
  logic [63:0]          mem_rdata;

  logic [63:0] mem [0:DEPTH-1];

  assign req          = memRead | memWrite;
  assign word_idx     = addr_q[ADDR_BITS+2:3];
  // Misaligned low bits, or any address bit above the array's byte range.
  assign access_fault = (|addr_q[2:0]) | (|addr_q[63:ADDR_BITS+3]);
  assign mem_rdata    = mem[word_idx];

  // Next-state, latching and access decisions for the request FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    read_data_d = read_data_q;
    fault_d     = 1'b0;
    mem_we      = 1'b0;
    stall_int   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_int = req;
        if (req) begin
          addr_d     = address;
          wdata_d    = writeData;
          // Simultaneous read+write is treated as a write.
          is_write_d = memWrite;
          cnt_d      = CNT_INIT;
          state_d    = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall_int = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          if (access_fault) begin
            fault_d = 1'b1;
            if (!is_write_q) begin
              read_data_d = 64'd0;
            end else begin
              read_data_d = read_data_q;
            end
          end else if (is_write_q) begin
            mem_we = 1'b1;
          end else begin
            read_data_d = mem_rdata;
          end
        end
      end
      ST_DONE: begin
        // Request inputs here belong to the finished access; ignore them.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, latched request and registered outputs.
  always_ff @(posedge systemClock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      is_write_q  <= 1'b0;
      read_data_q <= 64'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
    end
  end

  // Storage array; deliberately not reset so contents survive a reset.
  always_ff @(posedge systemClock) begin
    if (mem_we) begin
      mem[word_idx] <= wdata_q;
    end
  end

  // stall is forced low while reset is held so the pipeline is released at once.
  assign stall    = stall_int & ~reset;
  assign readData = read_data_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int LAT = 3;

  logic        systemClock = 1'b0;
  logic        reset       = 1'b1;
  logic        memRead     = 1'b0;
  logic        memWrite    = 1'b0;
  logic [63:0] address     = 64'd0;
  logic [63:0] writeData   = 64'd0;
  logic [63:0] readData;
  logic        stall;
  logic        fault;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: word-addressed array, validity flags, expected readData.
  logic [63:0] mdl_mem   [256];
  bit          mdl_valid [256];
  logic [63:0] mdl_rd = 64'd0;

  data_mem_responder #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(LAT)) dut (
    .systemClock(systemClock),
    .reset      (reset),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .address    (address),
    .writeData  (writeData),
    .readData   (readData),
    .stall      (stall),
    .fault      (fault)
  );

  always #5 systemClock = ~systemClock;

  always @(posedge systemClock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one access at a falling edge, wait (bounded) for the DONE cycle,
  // then check stall length, fault and readData against the model.
  task automatic run(input bit rd, input bit wr, input logic [63:0] a,
                     input logic [63:0] d, input string tag, output int start_cyc);
    bit flt;
    int idx;
    int sc;
    @(negedge systemClock);
    memRead   = rd;
    memWrite  = wr;
    address   = a;
    writeData = d;
    start_cyc = cyc;
    flt = ((a % 64'd8) != 64'd0) || (a >= 64'd2048);
    idx = int'((a / 64'd8) % 64'd256);
    if (wr) begin
      if (!flt) begin
        mdl_mem[idx]   = d;
        mdl_valid[idx] = 1'b1;
      end
    end else if (flt) begin
      mdl_rd = 64'd0;
    end else begin
      mdl_rd = mdl_mem[idx];
    end
    sc = 0;
    #1;
    while (stall === 1'b1 && sc < 40) begin
      sc++;
      @(negedge systemClock);
      #1;
    end
    check({tag, "_stall_cycles"}, 64'(sc), 64'(LAT + 1));
    check({tag, "_fault"}, {63'd0, fault}, {63'd0, flt});
    check({tag, "_readData"}, readData, mdl_rd);
  endtask

  task automatic idle_check(input string tag);
    @(negedge systemClock);
    memRead  = 1'b0;
    memWrite = 1'b0;
    #1;
    check({tag, "_idle_stall"}, {63'd0, stall}, 64'd0);
    check({tag, "_idle_fault"}, {63'd0, fault}, 64'd0);
  endtask

  initial begin
    int t0;
    int tdummy;
    int ridx;
    bit rd;
    bit wr;
    logic [63:0] a;
    logic [63:0] d;

    // Reset state
    #1;
    check("reset_readData", readData, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);
    check("reset_fault", {63'd0, fault}, 64'd0);
    @(negedge systemClock);
    reset = 1'b0;

    // 1: write then read back
    run(1'b0, 1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, "t1_wr", tdummy);
    run(1'b1, 1'b0, 64'h10, 64'd0, "t1_rd", tdummy);

    // 2: write then back-to-back held read, 10 cycles total
    run(1'b0, 1'b1, 64'h0, 64'h1, "t2_wr", t0);
    run(1'b1, 1'b0, 64'h0, 64'd0, "t2_rd", tdummy);
    check("t2_total_cycles", 64'(cyc - t0 + 1), 64'd10);
    idle_check("t2");

    // 3: misaligned write faults, memory untouched
    run(1'b0, 1'b1, 64'h10, 64'h55, "t3_wr", tdummy);
    run(1'b0, 1'b1, 64'h13, 64'hFF, "t3_mis", tdummy);
    idle_check("t3");
    run(1'b1, 1'b0, 64'h10, 64'd0, "t3_rd", tdummy);

    // 4: out-of-range read faults with zero data, last word is fine
    run(1'b0, 1'b1, 64'h7F8, 64'h1234, "t4_wr", tdummy);
    run(1'b1, 1'b0, 64'h800, 64'd0, "t4_oor", tdummy);
    run(1'b1, 1'b0, 64'h7F8, 64'd0, "t4_rd", tdummy);

    // 5: reset during WAIT discards the pending write
    run(1'b0, 1'b1, 64'h20, 64'hAA, "t5_wr", tdummy);
    run(1'b1, 1'b0, 64'h20, 64'd0, "t5_rd0", tdummy);
    @(negedge systemClock);
    memRead   = 1'b0;
    memWrite  = 1'b1;
    address   = 64'h20;
    writeData = 64'hBB;
    @(negedge systemClock);
    #1;
    check("t5_wait1_stall", {63'd0, stall}, 64'd1);
    @(negedge systemClock);
    reset    = 1'b1;
    memWrite = 1'b0;
    mdl_rd   = 64'd0;
    #1;
    check("t5_rst_stall", {63'd0, stall}, 64'd0);
    check("t5_rst_readData", readData, 64'd0);
    @(negedge systemClock);
    reset = 1'b0;
    run(1'b1, 1'b0, 64'h20, 64'd0, "t5_rd", tdummy);

    // 6: read+write together is a write, readData unchanged
    run(1'b1, 1'b1, 64'h18, 64'h77, "t6_both", tdummy);
    run(1'b1, 1'b0, 64'h18, 64'd0, "t6_rd", tdummy);

    // Randomized accesses against the model
    for (int i = 0; i < 24; i++) begin
      ridx = int'($urandom_range(0, 7));
      a    = 64'h100 + 64'(ridx) * 64'd8;
      d    = {$urandom, $urandom};
      wr   = 1'($urandom_range(0, 1));
      rd   = !wr || ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: a = a + 64'($urandom_range(1, 7));
        1: a = a | (64'd1 << $urandom_range(11, 63));
        default: a = a;
      endcase
      if (!wr && !mdl_valid[32 + ridx] && a < 64'd2048 && (a % 64'd8) == 64'd0) begin
        wr = 1'b1;
      end
      run(rd, wr, a, d, $sformatf("rnd%0d", i), tdummy);
    end
    idle_check("end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder for the MEM stage.
- Answers the pipeline's memRead/memWrite doubleword requests (ld/sd) with a configurable access latency.
- Drives a stall output so the pipeline holds PC, IF/ID, ID/EX and EX/MEM until the access completes.
- Replaces the single-cycle data memory in the pipelined top; the requests come from the EX/MEM register outputs.

Parameters:
DEPTH, 256, number of 64-bit words stored; must be a power of two.
ADDR_BITS, 8, log2(DEPTH); word-index width.
LATENCY, 3, cycles spent in WAIT per access; legal range 1..15.

Ports:
systemClock  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
memRead  input  1  load request from EX/MEM; held stable by the pipeline while stall=1.
memWrite  input  1  store request from EX/MEM; held stable while stall=1.
address  input  64  byte address (EX/MEM ALU result).
writeData  input  64  store data (EX/MEM rs2 value).
readData  output  64  load result; registered; valid in the DONE cycle and held afterwards.
stall  output  1  high while a request is pending; pipeline freezes while high.
fault  output  1  high for the single DONE cycle of a faulted access.

Behaviour:
- Reset: systemClock and reset as named above; reset is asynchronous, active-high.
  - On reset: state=IDLE, latency counter=0, readData=0, fault=0, latched request cleared.
  - Memory array contents are not affected by reset.
- State IDLE:
  - req = memRead | memWrite.
  - stall = req (combinational, same cycle).
  - If req, the next edge latches address, writeData and op, then moves to WAIT with cnt=LATENCY-1.
  - If memRead and memWrite are both high, the access is a write; readData is untouched.
- State WAIT:
  - stall=1.
  - cnt≠0: decrement cnt.
  - cnt=0: at the edge, perform the access and go to DONE.
- Access rules (applied at the WAIT→DONE edge):
  - Word index = latched address[ADDR_BITS+2:3].
  - Fault when address[2:0]≠0 (misaligned) or address[63:ADDR_BITS+3]≠0 (out of range).
  - Write, no fault: mem[index] ← latched writeData.
  - Read, no fault: readData ← mem[index].
  - Fault: memory not written; a faulted read sets readData=0; fault set to 1.
- State DONE:
  - stall=0 and fault is valid; the pipeline advances at this edge.
  - Request inputs in this cycle belong to the completed access and are ignored.
  - Next state is always IDLE; fault returns to 0.
- Timing:
  - Total stall cycles per access = LATENCY+1.
  - Minimum request spacing = LATENCY+2 cycles.
- readData changes only on read completion or reset.
- Reset during WAIT/DONE: stall drops immediately; a pending write is discarded (no memory update).
- Inputs changing while in WAIT have no effect (latched copy used).

Test Plan:
1. Reset; write 0xDEADBEEFCAFEF00D to 0x10 (LATENCY=3) → stall high 4 cycles, low in DONE; then read 0x10 → stall 4 cycles, readData=0xDEADBEEFCAFEF00D in DONE cycle, fault=0.
2. Write 0x1 to 0x0, then hold a read of 0x0 continuously → read accepted in the cycle after DONE; exactly two accesses; readData=0x1, total 10 cycles.
3. Write 0x55 to 0x10, then write 0xFF to misaligned 0x13 → fault=1 in DONE only; read 0x10 returns 0x55.
4. Read 0x800 (DEPTH=256, out of range) → fault=1, readData=0; a later read 0x7F8 completes with fault=0.
5. Write 0xAA to 0x20; start write 0xBB to 0x20, pulse reset in its second WAIT cycle → stall=0 and readData=0 immediately; read 0x20 returns 0xAA.
6. memRead=memWrite=1, address 0x18, writeData 0x77 → treated as write, readData unchanged; subsequent read 0x18 returns 0x77.
